// File: rtl/xbar_alloc.sv
// rtl/xbar_alloc.sv - 4x4 crossbar output allocator with per-output packet locking
//
// Each of the four outputs runs its own IDLE/LOCKED FSM. In IDLE it picks one
// requesting input round-robin (search starts after the last owner). It then
// holds that input until a beat with last=1 transfers. After every release
// there is one IDLE cycle.
//
// Optional feature: define XBAR_TIMEOUT_EN to add a per-output stall timeout.
// A LOCKED output that sees TO_CYC consecutive cycles without a valid beat
// is released, and err_timeout pulses for that output.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_in      in   synchronous active-high reset
//   req_vld     in   [3:0] per-input beat valid
//   req_dst     in   [7:0] per-input destination, input i at [2i+1:2i]
//   req_last    in   [3:0] per-input last beat of packet
//   out_rdy     in   [3:0] per-output downstream ready
//   req_rdy     out  [3:0] per-input beat accepted this cycle
//   out_vld     out  [3:0] per-output beat valid
//   out_sel     out  [7:0] per-output owner index, output o at [2o+1:2o]
//   out_lock    out  [3:0] per-output locked flag
//   err_timeout out  [3:0] per-output one-cycle timeout pulse
module xbar_alloc #(
  parameter int TO_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [3:0] req_vld,
  input  logic [7:0] req_dst,
  input  logic [3:0] req_last,
  input  logic [3:0] out_rdy,
  output logic [3:0] req_rdy,
  output logic [3:0] out_vld,
  output logic [7:0] out_sel,
  output logic [3:0] out_lock,
  output logic [3:0] err_timeout
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state [4];
  logic [1:0] owner [4];
  logic [1:0] ptr   [4];

  logic [3:0] busy;
  logic [3:0] dst_ok;
  logic [3:0] vld_raw;
  logic [3:0] xfer;
  logic [3:0] win_vld;
  logic [1:0] win   [4];

  // Round-robin search. Scanning from the farthest slot down to ptr+1 means
  // the slot nearest to ptr+1 overwrites all the others, so it wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (cand[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Inputs that currently own an output. They are kept out of other outputs'
  // arbitration, so an owner that retargets mid-packet cannot grab a second lock.
  always_comb begin
    busy = '0;
    for (int o = 0; o < 4; o++) begin
      if (state[o] == LOCKED) busy[owner[o]] = 1'b1;
    end
  end

  always_comb begin
    logic [3:0] cand;
    logic [2:0] pick;
    for (int o = 0; o < 4; o++) begin
      dst_ok[o]  = (req_dst[{owner[o], 1'b0} +: 2] == 2'(o));
      vld_raw[o] = (state[o] == LOCKED) && req_vld[owner[o]] && dst_ok[o];
      xfer[o]    = vld_raw[o] && out_rdy[o];
      cand = '0;
      for (int i = 0; i < 4; i++) begin
        cand[i] = req_vld[i] && (req_dst[2*i +: 2] == 2'(o)) && !busy[i];
      end
      pick       = rr_pick(cand, ptr[o]);
      win_vld[o] = pick[2];
      win[o]     = pick[1:0];
    end
  end

  always_comb begin
    req_rdy = '0;
    for (int o = 0; o < 4; o++) begin
      if (!rst_in && state[o] == LOCKED && dst_ok[o]) req_rdy[owner[o]] = out_rdy[o];
    end
  end

  assign out_vld = rst_in ? 4'b0000 : vld_raw;

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      out_sel[2*o +: 2] = owner[o];
      out_lock[o]       = (state[o] == LOCKED);
    end
  end

`ifdef XBAR_TIMEOUT_EN
  logic [15:0] cnt [4];
  logic [3:0]  err_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int o = 0; o < 4; o++) begin
        state[o] <= IDLE;
        owner[o] <= 2'd0;
        ptr[o]   <= 2'd3;
        cnt[o]   <= '0;
      end
      err_q <= '0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        err_q[o] <= 1'b0;
        case (state[o])
          IDLE: begin
            if (win_vld[o]) begin
              state[o] <= LOCKED;
              owner[o] <= win[o];
              cnt[o]   <= '0;
            end
          end
          LOCKED: begin
            if (xfer[o] && req_last[owner[o]]) begin
              state[o] <= IDLE;
              ptr[o]   <= owner[o];
            end else if (vld_raw[o]) begin
              cnt[o] <= '0;
            end else if (cnt[o] == 16'(TO_CYC - 1)) begin
              // This is the TO_CYC-th consecutive stalled cycle.
              state[o] <= IDLE;
              ptr[o]   <= owner[o];
              err_q[o] <= 1'b1;
              cnt[o]   <= '0;
            end else begin
              cnt[o] <= cnt[o] + 16'd1;
            end
          end
          default: state[o] <= IDLE;
        endcase
      end
    end
  end

  assign err_timeout = rst_in ? 4'b0000 : err_q;
`else
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int o = 0; o < 4; o++) begin
        state[o] <= IDLE;
        owner[o] <= 2'd0;
        ptr[o]   <= 2'd3;
      end
    end else begin
      for (int o = 0; o < 4; o++) begin
        case (state[o])
          IDLE: begin
            if (win_vld[o]) begin
              state[o] <= LOCKED;
              owner[o] <= win[o];
            end
          end
          LOCKED: begin
            if (xfer[o] && req_last[owner[o]]) begin
              state[o] <= IDLE;
              ptr[o]   <= owner[o];
            end
          end
          default: state[o] <= IDLE;
        endcase
      end
    end
  end

  // TO_CYC has no effect without the timeout; referencing it here folds to zero.
  assign err_timeout = 4'(0 * TO_CYC);
`endif

endmodule

// File: tb/tb_xbar_alloc.sv
// tb/tb_xbar_alloc.sv - randomized and directed bench for xbar_alloc against a behavioural model
module tb_xbar_alloc;

`ifdef XBAR_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_in;
  logic [3:0] req_vld, req_last, out_rdy;
  logic [7:0] req_dst;
  logic [3:0] req_rdy, out_vld, out_lock, err_timeout;
  logic [7:0] out_sel;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  xbar_alloc #(.TO_CYC(TO)) dut (
    .clk(clk), .rst_in(rst_in), .req_vld(req_vld), .req_dst(req_dst),
    .req_last(req_last), .out_rdy(out_rdy), .req_rdy(req_rdy), .out_vld(out_vld),
    .out_sel(out_sel), .out_lock(out_lock), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dst_of(int i);
    return int'(req_dst[2*i +: 2]);
  endfunction

  // Behavioural model: per output a locked flag, an owner, a last-owner
  // pointer and a stall count.
  bit m_lock [4];
  int m_own  [4] = '{0, 0, 0, 0};
  int m_ptr  [4] = '{3, 3, 3, 3};
  int m_cnt  [4];
  bit m_err  [4];

  always @(negedge clk) begin
    logic [3:0] e_rdy, e_vld, e_lock, e_err;
    logic [7:0] e_sel;
    bit busy [4];
    bit n_lock [4];
    int n_own [4], n_ptr [4], n_cnt [4];
    bit n_err [4];
    bit found;
    int cand;
    if (chk_en) begin
      e_rdy = '0;
      e_vld = '0;
      for (int o = 0; o < 4; o++) begin
        e_lock[o] = m_lock[o];
        e_sel[2*o +: 2] = 2'(m_own[o]);
        e_err[o] = m_err[o] && !rst_in;
        if (m_lock[o] && !rst_in && dst_of(m_own[o]) == o) begin
          e_vld[o] = req_vld[m_own[o]];
          e_rdy[m_own[o]] = out_rdy[o];
        end
      end
      check("req_rdy", 32'(req_rdy), 32'(e_rdy));
      check("out_vld", 32'(out_vld), 32'(e_vld));
      check("out_sel", 32'(out_sel), 32'(e_sel));
      check("out_lock", 32'(out_lock), 32'(e_lock));
      check("err_timeout", 32'(err_timeout), 32'(e_err));

      for (int i = 0; i < 4; i++) busy[i] = 1'b0;
      for (int o = 0; o < 4; o++) if (m_lock[o]) busy[m_own[o]] = 1'b1;

      for (int o = 0; o < 4; o++) begin
        n_lock[o] = m_lock[o];
        n_own[o]  = m_own[o];
        n_ptr[o]  = m_ptr[o];
        n_cnt[o]  = m_cnt[o];
        n_err[o]  = 1'b0;
        if (m_lock[o]) begin
          if (e_vld[o] && out_rdy[o] && req_last[m_own[o]]) begin
            n_lock[o] = 1'b0;
            n_ptr[o]  = m_own[o];
          end else if (e_vld[o]) begin
            n_cnt[o] = 0;
          end else begin
            n_cnt[o] = m_cnt[o] + 1;
`ifdef XBAR_TIMEOUT_EN
            if (n_cnt[o] == TO) begin
              n_lock[o] = 1'b0;
              n_ptr[o]  = m_own[o];
              n_err[o]  = 1'b1;
              n_cnt[o]  = 0;
            end
`endif
          end
        end else begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            cand = (m_ptr[o] + k) % 4;
            if (!found && req_vld[cand] && dst_of(cand) == o && !busy[cand]) begin
              found     = 1'b1;
              n_lock[o] = 1'b1;
              n_own[o]  = cand;
              n_cnt[o]  = 0;
            end
          end
        end
      end

      for (int o = 0; o < 4; o++) begin
        if (rst_in) begin
          m_lock[o] = 1'b0; m_own[o] = 0; m_ptr[o] = 3; m_cnt[o] = 0; m_err[o] = 1'b0;
        end else begin
          m_lock[o] = n_lock[o]; m_own[o] = n_own[o]; m_ptr[o] = n_ptr[o];
          m_cnt[o] = n_cnt[o]; m_err[o] = n_err[o];
        end
      end
    end
  end

  initial begin
    int g [$];
    int xfers, beats, lost, pulses;
    bit locked_all;
    int pat [4] = '{1, 0, 1, 1};
    logic [1:0] sd [4];

    rst_in = 1'b1; req_vld = '0; req_dst = '0; req_last = '0; out_rdy = '0;
    tick(); tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_lock", 32'(out_lock), 32'h0);
    check("reset_sel", 32'(out_sel), 32'h0);
    check("reset_rdy", 32'(req_rdy), 32'h0);
    tick();
    rst_in = 1'b0;

    // Round-robin on output 0 with single-beat packets.
    req_vld = 4'b1011; req_dst = 8'h00; req_last = 4'b1011; out_rdy = 4'hf;
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_lock[0] && out_sel[1:0] != 2'(g.size() > 0 ? g[g.size()-1] : 9) && (c % 2 == 1))
        g.push_back(int'(out_sel[1:0]));
      else if (out_lock[0] && (c % 2 == 1))
        g.push_back(int'(out_sel[1:0]));
      if (out_vld[0] && out_rdy[0]) xfers++;
      tick();
    end
    req_vld = '0; req_last = '0;
    check("rr_grants", 32'(g.size()), 32'd4);
    if (g.size() == 4) begin
      check("rr_g0", 32'(g[0]), 32'd0);
      check("rr_g1", 32'(g[1]), 32'd1);
      check("rr_g2", 32'(g[2]), 32'd3);
      check("rr_g3", 32'(g[3]), 32'd0);
    end
    check("rr_xfers", 32'(xfers), 32'd4);
    tick();

    // Three-beat packet from input 2 to output 1 with a ready gap.
    req_vld = 4'b0100; req_dst = 8'h10; req_last = '0; out_rdy = '0;
    tick();
    beats = 0; locked_all = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_rdy[1] = pat[k][0];
      req_last[2] = (beats == 2);
      @(negedge clk);
      if (!out_lock[1]) locked_all = 1'b0;
      if (out_vld[1] && out_rdy[1]) beats++;
      tick();
    end
    req_vld = '0; req_last = '0; out_rdy = '0;
    @(negedge clk);
    check("pkt_beats", 32'(beats), 32'd3);
    check("pkt_locked", 32'(locked_all), 32'd1);
    check("pkt_release", 32'(out_lock[1]), 32'd0);
    tick();

    // Concurrent locks: input 0 -> output 2, input 1 -> output 3.
    req_vld = 4'b0011; req_dst = 8'h0E; req_last = '0; out_rdy = 4'b1100;
    tick();
    @(negedge clk);
    check("dual_lock", 32'(out_lock), 32'b1100);
    check("dual_sel", 32'(out_sel[7:4]), 32'b0100);
    check("dual_vld", 32'(out_vld[3:2]), 32'b11);
    check("dual_rdy", 32'(req_rdy[1:0]), 32'b11);
    tick();
    req_last = 4'b0011;
    tick();
    req_vld = '0; req_last = '0; out_rdy = '0;
    tick();

    // Reset during beat 2 of a packet; afterwards lowest candidate wins.
    req_vld = 4'b0100; req_dst = 8'h00; out_rdy = 4'b0001;
    tick();
    req_vld = 4'b1110;
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_drop_lock", 32'(out_lock), 32'h0);
    tick();
    @(negedge clk);
    check("rst_regrant_lock", 32'(out_lock[0]), 32'd1);
    check("rst_regrant_sel", 32'(out_sel[1:0]), 32'd1);
    req_vld = '0; out_rdy = '0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;

    // Owner stalls on output 3.
    req_vld = 4'b0001; req_dst = 8'h03; req_last = '0; out_rdy = 4'b1000;
    tick(); tick();
    req_vld = '0;
    lost = 0; pulses = 0;
`ifdef XBAR_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (err_timeout[3]) pulses++;
      tick();
    end
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_idle", 32'(out_lock[3]), 32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!out_lock[3]) lost++;
      if (err_timeout != 4'b0000) pulses++;
      tick();
    end
    check("hold_lost", 32'(lost), 32'd0);
    check("hold_err", 32'(pulses), 32'd0);
`endif
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;

    // Randomized traffic; destinations are sticky so packets usually complete.
    for (int i = 0; i < 4; i++) sd[i] = 2'($urandom_range(3));
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) sd[i] = 2'($urandom_range(3));
        req_dst[2*i +: 2] = sd[i];
      end
      req_vld  = ~(4'($urandom) & 4'($urandom));
      req_last = 4'($urandom) & 4'($urandom);
      out_rdy  = 4'($urandom) | 4'($urandom);
      rst_in   = ($urandom_range(299) == 0);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
